// File: rtl/psram_pkg.sv
// psram_pkg: widths and enums shared by the PSRAM arbiter files.
package psram_pkg;

   localparam int PSRAM_ADDR_W = 21;
   localparam int PSRAM_DATA_W = 16;

   typedef enum logic {
      OP_RD,
      OP_WR
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } state_e;

endpackage

// File: rtl/psram_arb_grant.sv
// psram_arb_grant: read-over-write grant select for the PSRAM arbiter.
// Build with PSRAM_ARB_FAIRNESS_EN to cap read streaks while a write waits.
module psram_arb_grant #(
   parameter int MAX_RD_STREAK = 4
) (
`ifdef PSRAM_ARB_FAIRNESS_EN
   input  logic clk,
   input  logic reset,
`endif
   input  logic grant_en,
   input  logic rd_req,
   input  logic wr_req,
   output logic gnt_rd,
   output logic gnt_wr
);

`ifdef PSRAM_ARB_FAIRNESS_EN
   localparam int CNT_W = $clog2(MAX_RD_STREAK + 1);

   logic [CNT_W-1:0] streak_q;
   logic [CNT_W-1:0] streak_d;
   logic             wr_turn;

   always_comb begin
      wr_turn  = wr_req && (streak_q >= CNT_W'(MAX_RD_STREAK));
      gnt_wr   = grant_en && wr_req && (!rd_req || wr_turn);
      gnt_rd   = grant_en && rd_req && !gnt_wr;
      streak_d = streak_q;
      // Only reads that overtake a waiting write count toward the cap.
      if (gnt_wr) begin
         streak_d = '0;
      end else if (gnt_rd) begin
         streak_d = wr_req ? streak_q + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   localparam int unused_streak = MAX_RD_STREAK;

   always_comb begin
      gnt_rd = grant_en && rd_req;
      gnt_wr = grant_en && wr_req && !rd_req;
   end
`endif

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PsramController port between loader writes
// and readout reads; optional fairness via PSRAM_ARB_FAIRNESS_EN.
module psram_arbiter
   import psram_pkg::*;
#(
   parameter int ADDR_W        = PSRAM_ADDR_W,
   parameter int DATA_W        = PSRAM_DATA_W,
   parameter int BUSY_TIMEOUT  = 8,
   parameter int MAX_RD_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W:0]   mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_busy,
   output logic              arb_busy,
   output logic              err_timeout
);

   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              rd_ack_q, rd_ack_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_done_q, wr_done_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              err_q, err_d;

   logic gnt_en;
   logic gnt_rd;
   logic gnt_wr;
   logic tmo_hit;

   assign gnt_en  = (state_q == ST_IDLE) && !mem_busy;
   assign tmo_hit = (tmo_q == TMO_W'(BUSY_TIMEOUT - 1));

   psram_arb_grant #(
      .MAX_RD_STREAK(MAX_RD_STREAK)
   ) u_grant (
`ifdef PSRAM_ARB_FAIRNESS_EN
      .clk     (clk),
      .reset   (reset),
`endif
      .grant_en(gnt_en),
      .rd_req  (rd_req),
      .wr_req  (wr_req),
      .gnt_rd  (gnt_rd),
      .gnt_wr  (gnt_wr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_RD;
         addr_q      <= '0;
         din_q       <= '0;
         rd_data_q   <= '0;
         tmo_q       <= '0;
         rd_ack_q    <= 1'b0;
         wr_ack_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         wr_done_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rd_data_q   <= rd_data_d;
         tmo_q       <= tmo_d;
         rd_ack_q    <= rd_ack_d;
         wr_ack_q    <= wr_ack_d;
         rd_valid_q  <= rd_valid_d;
         wr_done_q   <= wr_done_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (gnt_rd || gnt_wr) state_d = ST_ISSUE;
         ST_ISSUE:     state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (mem_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_hit) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_DONE: if (!mem_busy) state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      op_d        = op_q;
      addr_d      = addr_q;
      din_d       = din_q;
      rd_data_d   = rd_data_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      rd_ack_d    = 1'b0;
      wr_ack_d    = 1'b0;
      rd_valid_d  = 1'b0;
      wr_done_d   = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (gnt_rd) begin
               rd_ack_d = 1'b1;
               addr_d   = rd_addr;
               op_d     = OP_RD;
            end else if (gnt_wr) begin
               wr_ack_d = 1'b1;
               addr_d   = wr_addr;
               din_d    = wr_data;
               op_d     = OP_WR;
            end
         end
         ST_ISSUE: begin
            mem_read_d  = (op_q == OP_RD);
            mem_write_d = (op_q == OP_WR);
         end
         ST_WAIT_BUSY: begin
            // A controller that never goes busy still gets a completion.
            if (!mem_busy) begin
               if (tmo_hit) begin
                  err_d      = 1'b1;
                  rd_valid_d = (op_q == OP_RD);
                  wr_done_d  = (op_q == OP_WR);
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (!mem_busy) begin
               if (op_q == OP_RD) begin
                  rd_data_d  = mem_dout;
                  rd_valid_d = 1'b1;
               end else begin
                  wr_done_d = 1'b1;
               end
            end
         end
      endcase
   end

   assign rd_ack      = rd_ack_q;
   assign wr_ack      = wr_ack_q;
   assign rd_valid    = rd_valid_q;
   assign wr_done     = wr_done_q;
   assign rd_data     = rd_data_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = {addr_q, 1'b0};
   assign mem_din     = din_q;
   assign arb_busy    = (state_q != ST_IDLE);
   assign err_timeout = err_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: scoreboard bench with a behavioural PsramController.
// Build with PSRAM_ARB_FAIRNESS_EN to check the fairness variant.
module tb_psram_arbiter;

   localparam int AW = 21;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rd_req = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          rd_ack;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_req = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_ack;
   logic          wr_done;
   logic          mem_read;
   logic          mem_write;
   logic [AW:0]   mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout = '0;
   logic          mem_busy = 1'b0;
   logic          arb_busy;
   logic          err_timeout;

   always #5 clk = ~clk;

   psram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_ack     (rd_ack),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .wr_done    (wr_done),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mem_busy   (mem_busy),
      .arb_busy   (arb_busy),
      .err_timeout(err_timeout)
   );

   typedef struct {
      logic [AW:0]   addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mem_model[logic [AW:0]];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            busy_len = 6;
   int            busy_cnt = 0;
   bit            model_en = 1'b1;
   logic [DW-1:0] exp_rd_data = '0;

   // Controller model: busy for busy_len cycles after each strobe.
   initial begin
      forever begin
         @(negedge clk);
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) mem_busy = 1'b0;
         end else if (model_en && (mem_read || mem_write)) begin
            mem_busy = 1'b1;
            busy_cnt = busy_len;
            if (mem_write) begin
               mem_model[mem_addr] = mem_din;
            end else begin
               mem_dout = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({rd_ack, rd_valid, wr_ack, wr_done, mem_read, mem_write,
           arb_busy, err_timeout} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 0",
                  {rd_ack, rd_valid, wr_ack, wr_done, mem_read, mem_write,
                   arb_busy, err_timeout});
      end
      n_cmp++;
      if ({rd_data, mem_addr, mem_din} !== 54'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h want 0", {rd_data, mem_addr, mem_din});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_read();
      exp_t e;
      int   t;
      logic prev;
      busy_len = 6;
      mem_model[22'h000024] = 16'hBEEF;
      e.addr = 22'h000024;
      e.data = 16'hBEEF;
      sb.push_back(e);
      rd_addr = 21'h00012;
      rd_req  = 1'b1;
      tick();
      n_cmp++;
      if (rd_ack !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_ack_latency: got %b want 1", rd_ack);
      end
      rd_req  = 1'b0;
      rd_addr = '0;
      tick();
      n_cmp++;
      if ({mem_read, mem_write, mem_addr} !== {2'b10, 22'h000024}) begin
         n_bad++;
         $display("FAIL rd_strobe: got %b%b %h want 10 000024",
                  mem_read, mem_write, mem_addr);
      end
      t    = 0;
      prev = 1'b0;
      while (!rd_valid && t < 40) begin
         prev = mem_busy;
         tick();
         t++;
      end
      n_cmp++;
      if (t != 7 || prev !== 1'b1) begin
         n_bad++;
         $display("FAIL rd_valid_timing: got %0d cycles busy_before=%b want 7 1",
                  t, prev);
      end
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e.data || mem_addr !== e.addr) begin
         n_bad++;
         $display("FAIL rd_result: got v=%b d=%h a=%h want 1 %h %h",
                  rd_valid, rd_data, mem_addr, e.data, e.addr);
      end
      exp_rd_data = e.data;
      tick();
      n_cmp++;
      if ({rd_valid, arb_busy} !== 2'b00 || rd_data !== exp_rd_data) begin
         n_bad++;
         $display("FAIL rd_pulse_hold: got v=%b b=%b d=%h want 0 0 %h",
                  rd_valid, arb_busy, rd_data, exp_rd_data);
      end
   endtask

   task automatic test_single_write();
      exp_t e;
      int   t;
      int   bad;
      busy_len = 5;
      e.addr = 22'h3FFFFE;
      e.data = 16'hA55A;
      sb.push_back(e);
      wr_addr = 21'h1FFFFF;
      wr_data = 16'hA55A;
      wr_req  = 1'b1;
      tick();
      n_cmp++;
      if ({wr_ack, rd_ack} !== 2'b10) begin
         n_bad++;
         $display("FAIL wr_ack_latency: got %b%b want 10", wr_ack, rd_ack);
      end
      wr_req  = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      tick();
      n_cmp++;
      if ({mem_write, mem_read, mem_addr, mem_din} !==
          {2'b10, sb[0].addr, sb[0].data}) begin
         n_bad++;
         $display("FAIL wr_strobe: got %b%b %h %h want 10 %h %h",
                  mem_write, mem_read, mem_addr, mem_din, sb[0].addr, sb[0].data);
      end
      t   = 0;
      bad = 0;
      while (!wr_done && t < 40) begin
         if (!arb_busy || mem_addr !== sb[0].addr || mem_din !== sb[0].data) bad++;
         tick();
         t++;
      end
      e = sb.pop_front();
      n_cmp++;
      if (wr_done !== 1'b1 || bad != 0) begin
         n_bad++;
         $display("FAIL wr_hold: got done=%b unstable=%0d want 1 0", wr_done, bad);
      end
      n_cmp++;
      if (!mem_model.exists(e.addr) || mem_model[e.addr] !== e.data) begin
         n_bad++;
         $display("FAIL wr_stored: got %h want %h",
                  mem_model.exists(e.addr) ? mem_model[e.addr] : 16'hxxxx, e.data);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      exp_t e;
      int   tv;
      int   ta;
      busy_len = 3;
      mem_model[22'h000200] = 16'hC0DE;
      e.addr = 22'h000200;
      e.data = 16'hC0DE;
      sb.push_back(e);
      e.addr = 22'h000400;
      e.data = 16'h1234;
      sb.push_back(e);
      rd_addr = 21'h00100;
      wr_addr = 21'h00200;
      wr_data = 16'h1234;
      rd_req  = 1'b1;
      wr_req  = 1'b1;
      tick();
      n_cmp++;
      if ({rd_ack, wr_ack} !== 2'b10) begin
         n_bad++;
         $display("FAIL simul_first: got rd=%b wr=%b want 1 0", rd_ack, wr_ack);
      end
      rd_req = 1'b0;
      tv = -100;
      ta = -200;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (rd_valid) begin
            tv = i;
            e  = sb.pop_front();
            n_cmp++;
            if (rd_data !== e.data) begin
               n_bad++;
               $display("FAIL simul_rd_data: got %h want %h", rd_data, e.data);
            end
            exp_rd_data = e.data;
         end
         if (wr_ack) begin
            ta = i;
            break;
         end
      end
      wr_req = 1'b0;
      n_cmp++;
      if (ta != tv + 1) begin
         n_bad++;
         $display("FAIL simul_wr_after_idle: got ack@%0d valid@%0d want ack=valid+1",
                  ta, tv);
      end
      for (int i = 0; i < 40 && !wr_done; i++) tick();
      e = sb.pop_front();
      n_cmp++;
      if (wr_done !== 1'b1 || !mem_model.exists(e.addr) || mem_model[e.addr] !== e.data) begin
         n_bad++;
         $display("FAIL simul_wr_done: got done=%b want 1 data %h", wr_done, e.data);
      end
      tick();
   endtask

   task automatic test_fairness();
      exp_t e;
      int   n_rd;
      bit   got_wr;
      bit   got_done;
      busy_len = 2;
      mem_model[22'h000020] = 16'h5A5A;
      rd_addr  = 21'h00010;
      wr_addr  = 21'h00030;
      wr_data  = 16'h7777;
      rd_req   = 1'b1;
      wr_req   = 1'b1;
      n_rd     = 0;
      got_wr   = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         tick();
         if (rd_valid) begin
            e = sb.pop_front();
            n_cmp++;
            if (rd_data !== e.data) begin
               n_bad++;
               $display("FAIL fair_rd_data: got %h want %h", rd_data, e.data);
            end
            exp_rd_data = e.data;
         end
         if (rd_ack) begin
            n_rd++;
            e.addr = 22'h000020;
            e.data = 16'h5A5A;
            sb.push_back(e);
         end
         if (wr_ack) begin
            got_wr = 1'b1;
            break;
         end
         if (n_rd >= 100) break;
      end
      rd_req = 1'b0;
`ifdef PSRAM_ARB_FAIRNESS_EN
      n_cmp++;
      if (!got_wr || n_rd != 4) begin
         n_bad++;
         $display("FAIL fair_streak: got wr_ack=%b after %0d reads want 1 after 4",
                  got_wr, n_rd);
      end
`else
      n_cmp++;
      if (got_wr || n_rd != 100) begin
         n_bad++;
         $display("FAIL strict_priority: got wr_ack=%b after %0d reads want 0 after 100",
                  got_wr, n_rd);
      end
`endif
      if (got_wr) wr_req = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (wr_ack) wr_req = 1'b0;
         if (wr_done) got_done = 1'b1;
         if (rd_valid) begin
            e = sb.pop_front();
            n_cmp++;
            if (rd_data !== e.data) begin
               n_bad++;
               $display("FAIL fair_drain_data: got %h want %h", rd_data, e.data);
            end
            exp_rd_data = e.data;
         end
         if (got_done && sb.size() == 0 && !arb_busy) break;
      end
      wr_req = 1'b0;
      n_cmp++;
      if (!got_done || !mem_model.exists(22'h000060) || mem_model[22'h000060] !== 16'h7777) begin
         n_bad++;
         $display("FAIL fair_wr_done: got done=%b want 1 with data 7777", got_done);
      end
      tick();
   endtask

   task automatic test_timeout();
      exp_t e;
      int   te;
      model_en = 1'b0;
      e.addr = 22'h000066;
      e.data = exp_rd_data;
      sb.push_back(e);
      rd_addr = 21'h00033;
      rd_req  = 1'b1;
      tick();
      rd_req = 1'b0;
      tick();
      n_cmp++;
      if ({mem_read, mem_addr} !== {1'b1, sb[0].addr}) begin
         n_bad++;
         $display("FAIL tmo_strobe: got %b %h want 1 %h", mem_read, mem_addr, sb[0].addr);
      end
      te = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (err_timeout) begin
            te = i;
            break;
         end
      end
      n_cmp++;
      if (te != 8) begin
         n_bad++;
         $display("FAIL tmo_latency: got %0d want 8", te);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({rd_valid, arb_busy} !== 2'b10 || rd_data !== e.data) begin
         n_bad++;
         $display("FAIL tmo_complete: got v=%b b=%b d=%h want 1 0 %h",
                  rd_valid, arb_busy, rd_data, e.data);
      end
      model_en = 1'b1;
      busy_len = 3;
      mem_model[22'h000088] = 16'h0F0F;
      e.addr = 22'h000088;
      e.data = 16'h0F0F;
      sb.push_back(e);
      rd_addr = 21'h00044;
      rd_req  = 1'b1;
      for (int i = 0; i < 10 && !rd_ack; i++) tick();
      rd_req = 1'b0;
      for (int i = 0; i < 40 && !rd_valid; i++) tick();
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e.data || err_timeout !== 1'b1) begin
         n_bad++;
         $display("FAIL tmo_recover: got v=%b d=%h err=%b want 1 %h 1",
                  rd_valid, rd_data, err_timeout, e.data);
      end
      exp_rd_data = e.data;
      tick();
   endtask

   task automatic test_reset_midflight();
      exp_t e;
      int   pulses;
      busy_len = 10;
      wr_addr  = 21'h00055;
      wr_data  = 16'h9999;
      wr_req   = 1'b1;
      tick();
      wr_req = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if ({arb_busy, mem_busy} !== 2'b11) begin
         n_bad++;
         $display("FAIL mid_inflight: got arb=%b mem=%b want 1 1", arb_busy, mem_busy);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if ({rd_ack, rd_valid, wr_ack, wr_done, mem_read, mem_write,
           arb_busy, err_timeout, rd_data, mem_addr, mem_din} !== 62'h0) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: got %h want 0",
                  {rd_ack, rd_valid, wr_ack, wr_done, mem_read, mem_write,
                   arb_busy, err_timeout, rd_data, mem_addr, mem_din});
      end
      exp_rd_data = '0;
      pulses = 0;
      repeat (14) begin
         tick();
         if (rd_valid || wr_done) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_bad++;
         $display("FAIL mid_no_completion: got %0d pulses want 0", pulses);
      end
      busy_len = 4;
      mem_model[22'h0000EE] = 16'h1357;
      e.addr = 22'h0000EE;
      e.data = 16'h1357;
      sb.push_back(e);
      rd_addr = 21'h00077;
      rd_req  = 1'b1;
      for (int i = 0; i < 20 && !rd_ack; i++) tick();
      rd_req = 1'b0;
      for (int i = 0; i < 40 && !rd_valid; i++) tick();
      e = sb.pop_front();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== e.data || err_timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_after_reset: got v=%b d=%h err=%b want 1 %h 0",
                  rd_valid, rd_data, err_timeout, e.data);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_simultaneous();
      test_fairness();
      test_timeout();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single PsramController port between two requesters:
  - the flash-to-PSRAM loader (write requester);
  - the video/UART readout fetch (read requester).
- Sequences one transaction at a time: issues the read/write strobe, holds address/data stable, waits out controller busy, and returns read data or write completion.
- Sits in the clk_sys domain between the requester logic and PsramController.

Parameters:
- ADDR_W, 21, word-address width of each requester (controller byte address is ADDR_W+1).
- DATA_W, 16, PSRAM word width.
- BUSY_TIMEOUT, 8, max cycles from strobe to controller busy rising before error.
- MAX_RD_STREAK, 4, consecutive read grants allowed while a write waits (fairness build only).

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request, held until rd_ack
- rd_addr  in  ADDR_W  read word address, valid while rd_req
- rd_ack  out  1  one-cycle pulse: request accepted, rd_addr latched
- rd_data  out  DATA_W  read word, valid with rd_valid, held until next read completes
- rd_valid  out  1  one-cycle pulse: rd_data valid
- wr_req  in  1  write request, held until wr_ack
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write word
- wr_ack  out  1  one-cycle pulse: wr_addr/wr_data latched
- wr_done  out  1  one-cycle pulse: write completed in PSRAM
- mem_read  out  1  one-cycle strobe to controller read
- mem_write  out  1  one-cycle strobe to controller write
- mem_addr  out  ADDR_W+1  {latched word addr, 1'b0}
- mem_din  out  DATA_W  latched write data
- mem_dout  in  DATA_W  controller read data
- mem_busy  in  1  controller busy
- arb_busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky: busy never rose after a strobe

Behaviour:
- Reset: all outputs 0, state IDLE, streak counter 0. Reset mid-transaction aborts immediately with no rd_valid/wr_done. PsramController reset is separate.
- IDLE:
  - Grants only when mem_busy=0.
  - Read has priority over write.
  - On grant: pulse ack; latch addr (and data for writes) plus an op flag; go to ISSUE.
  - No grant while mem_busy=1.
- ISSUE (1 cycle): pulse mem_read or mem_write; go to WAIT_BUSY.
- WAIT_BUSY:
  - mem_busy=1 -> WAIT_DONE.
  - Count cycles; at BUSY_TIMEOUT set err_timeout, complete as if done (rd_valid/wr_done with rd_data unchanged), return to IDLE.
- WAIT_DONE: on mem_busy=0:
  - Read: rd_data <= mem_dout; pulse rd_valid.
  - Write: pulse wr_done.
  - Go to IDLE.
- mem_addr/mem_din are stable from ISSUE through completion.
- Grant latency: ack in the cycle after req is seen in IDLE; strobe the cycle after ack.
- Ordering and rates:
  - Back-to-back requests have at least 1 IDLE cycle between transactions.
  - Simultaneous rd_req and wr_req: read granted; write stays pending (no ack).
  - A req dropped before ack is legal and ignored.
  - Requests never preempt an in-flight transaction.
- err_timeout is cleared only by reset.

Optional Feature:
- Macro: PSRAM_ARB_FAIRNESS_EN.
- Enabled:
  - Streak counter increments on each read grant made while wr_req=1.
  - When it reaches MAX_RD_STREAK with wr_req=1, the next grant goes to write and the counter clears.
  - The counter also clears on any write grant, and on a read grant with wr_req=0.
- Disabled: strict read priority; the write can starve indefinitely; the counter is not built.

Decomposition:
- Shared package psram_pkg: PSRAM_ADDR_W=21, PSRAM_DATA_W=16, op enum {OP_RD, OP_WR}, state enum {ST_IDLE, ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE}.
- One sub-module psram_arb_grant: combinational priority/fairness select plus streak counter. All other logic lives in psram_arbiter.

Test Plan:
- Single read, rd_addr=0x00012, model returns 0xBEEF after 6 busy cycles -> rd_ack 1 cycle after req; mem_read pulse with mem_addr=0x000024; rd_valid with rd_data=0xBEEF on the cycle after busy falls.
- Single write, wr_addr=0x1FFFFF, wr_data=0xA55A -> mem_write pulse, mem_addr=0x3FFFFE, mem_din=0xA55A stable until wr_done; arb_busy high throughout.
- rd_req and wr_req asserted the same cycle -> read acked first; write acked only after rd_valid plus 1 IDLE cycle.
- Fairness build: rd_req held continuously and wr_req held -> wr_ack after exactly 4 read grants. Non-fairness build: no wr_ack during 100 reads.
- Model never raises mem_busy after a strobe -> err_timeout=1 at strobe+8 cycles, rd_valid pulses, state returns to IDLE, next request served.
- reset asserted during WAIT_DONE -> next cycle all outputs 0; no rd_valid/wr_done; new request after reset served normally.
